// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES CTR image stream blocks (BRAM reader/writer).
//   streamer_state_t : reader FSM state encoding
//   KEEP_W()         : tkeep width for a given data width
//   byte_reverse()   : reverses the low data_w/8 bytes of a word (up to BSWAP_MAX_W bits)
package aes_stream_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } streamer_state_t;

  // Widest word byte_reverse() can handle; callers zero-extend into it.
  localparam int unsigned BSWAP_MAX_W = 1024;

  function automatic int unsigned KEEP_W(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Byte 0 of the input lands in the most significant byte of the data_w-bit result.
  function automatic logic [BSWAP_MAX_W-1:0] byte_reverse(input logic [BSWAP_MAX_W-1:0] d,
                                                          input int unsigned data_w);
    logic [BSWAP_MAX_W-1:0] r;
    int unsigned            nb;
    r  = '0;
    nb = data_w / 8;
    for (int unsigned i = 0; i < BSWAP_MAX_W / 8; i++) begin
      if (i < nb) r[8*i +: 8] = d[8*(nb-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry valid/ready FIFO used as the output skid buffer of the BRAM reader.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_data, i_valid       : write side; the writer guarantees space via o_count credits
//   o_data, o_valid       : read side, registered storage so data holds until popped
//   i_ready               : read side ready
//   o_count               : number of occupied entries (0..2)
module axis_skid_fifo2 #(
  parameter int unsigned WIDTH = 129
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_valid && (r_count != 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/bram_axis_streamer.sv
// Reads a programmable window of a 1-cycle-latency BRAM and streams it as AXI-Stream
// frames, optionally repeating the window several times.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, sampled only when idle
//   base_addr, length   : window start and beats per frame (latched on start)
//   frames              : repeat count, 0 behaves as 1 (latched on start)
//   busy, done          : job in progress / one-cycle completion pulse
//   bram_en, bram_addr  : BRAM read port; bram_dout valid the cycle after bram_en
//   m_axis_*            : AXI-Stream master
// Build option: define STREAMER_BSWAP_EN to byte-reverse each BRAM word onto tdata.
module bram_axis_streamer
  import aes_stream_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned FRAMES_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             length,
  input  logic [FRAMES_W-1:0]         frames,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_en,
  output logic [ADDR_W-1:0]           bram_addr,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W(DATA_W)-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  streamer_state_t     r_state;
  streamer_state_t     w_state_d;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_offset;
  logic [FRAMES_W-1:0] r_frames_m1;
  logic [FRAMES_W-1:0] r_frame;
  logic                r_rd_pend;
  logic                r_rd_last;
  logic [1:0]          w_count;
  logic [2:0]          w_occ;
  logic                w_pop;
  logic                w_rd_issue;
  logic                w_last_beat;
  logic                w_last_frame;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W:0]     w_fifo_out;

`ifdef STREAMER_BSWAP_EN
  assign w_rd_data = DATA_W'(byte_reverse(BSWAP_MAX_W'(bram_dout), DATA_W));
`else
  assign w_rd_data = bram_dout;
`endif

  // Occupancy as it will stand after this edge: current entries, minus the beat leaving
  // now, plus the read already in flight. Counting the pop keeps tready-high gapless.
  assign w_pop        = m_axis_tvalid && m_axis_tready;
  assign w_occ        = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_rd_pend};
  assign w_rd_issue   = (r_state == StRun) && (w_occ < 3'd2);
  assign w_last_beat  = (r_offset == (r_len - (ADDR_W+1)'(1)));
  assign w_last_frame = (r_frame == r_frames_m1);

  assign bram_en      = w_rd_issue;
  assign bram_addr    = r_base + r_offset[ADDR_W-1:0];  // wraps mod 2^ADDR_W
  assign busy         = (r_state == StRun) || (r_state == StDrain);
  assign done         = (r_state == StDone);
  assign m_axis_tkeep = '1;
  assign m_axis_tdata = w_fifo_out[DATA_W-1:0];
  assign m_axis_tlast = w_fifo_out[DATA_W];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = (length == '0) ? StDone : StRun;
      StRun:   if (w_rd_issue && w_last_beat && w_last_frame) w_state_d = StDrain;
      StDrain: if ((w_count == 2'd0) && !r_rd_pend) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_len       <= '0;
      r_offset    <= '0;
      r_frames_m1 <= '0;
      r_frame     <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && start) begin
        r_base      <= base_addr;
        r_len       <= length;
        r_offset    <= '0;
        r_frame     <= '0;
        r_frames_m1 <= (frames == '0) ? '0 : frames - FRAMES_W'(1);
      end else if (w_rd_issue) begin
        if (w_last_beat) begin
          r_offset <= '0;
          r_frame  <= r_frame + FRAMES_W'(1);
        end else begin
          r_offset <= r_offset + (ADDR_W+1)'(1);
        end
      end
      r_rd_pend <= w_rd_issue;
      r_rd_last <= w_rd_issue && w_last_beat;
    end
  end

  axis_skid_fifo2 #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  ({r_rd_last, w_rd_data}),
    .i_valid (r_rd_pend),
    .o_data  (w_fifo_out),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_count (w_count)
  );

endmodule
